// File: rtl/sine_phase_sequencer.sv
// Sine LUT address sequencer: prescaled sample tick, programmable phase step,
// run/stop control with a graceful stop that always lands on LUT index 0.
module sine_phase_sequencer #(
  parameter int LUT_SIZE    = 48,
  parameter int LUT_WIDTH   = 6,
  parameter int PRESC_WIDTH = 16,
  parameter int STEP_WIDTH  = 6
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
  input  logic [STEP_WIDTH-1:0]  cfg_step_i,
  output logic                   cfg_err_o,
  input  logic                   run_i,
  output logic [LUT_WIDTH-1:0]   lut_addr_o,
  output logic                   sample_stb_o,
  output logic                   busy_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  localparam logic [LUT_WIDTH:0]  SIZE_X   = (LUT_WIDTH+1)'(LUT_SIZE);
  localparam logic [STEP_WIDTH:0] STEP_LIM = (STEP_WIDTH+1)'(LUT_SIZE);

  state_e                 state_q, state_d;
  logic [LUT_WIDTH-1:0]   addr_q, addr_d;
  logic                   stb_q, stb_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [STEP_WIDTH-1:0]  step_q, step_d;
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

  logic                   tick;
  logic                   cfg_fire, cfg_ok;
  logic [LUT_WIDTH:0]     sum, sum_wr;
  logic                   wrap;
  logic [LUT_WIDTH-1:0]   addr_nxt;

  assign tick     = (state_q != S_IDLE) && (cnt_q == presc_q);
  assign sum      = {1'b0, addr_q} + (LUT_WIDTH+1)'(step_q);
  assign wrap     = (sum >= SIZE_X);
  assign sum_wr   = wrap ? (sum - SIZE_X) : sum;
  assign addr_nxt = sum_wr[LUT_WIDTH-1:0];

  // Config is only accepted while idle; rejected requests leave the registers alone.
  assign cfg_fire = cfg_valid_i && ready_q;
  assign cfg_ok   = (cfg_step_i != '0) && ({1'b0, cfg_step_i} < STEP_LIM);

  always_comb begin
    presc_d = presc_q;
    step_d  = step_q;
    err_d   = err_q;
    if (cfg_fire) begin
      if (cfg_ok) begin
        presc_d = cfg_presc_i;
        step_d  = cfg_step_i;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stb_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        cnt_d  = '0;
        if (run_i) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          addr_d = addr_nxt;
          stb_d  = 1'b1;
        end
        if (!run_i) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (run_i) begin
          state_d = S_RUN;
          if (tick) begin
            addr_d = addr_nxt;
            stb_d  = 1'b1;
          end
        end else if (addr_q == '0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          stb_d = 1'b1;
          // Crossing the table end lands exactly on midscale, then idles.
          if (wrap) begin
            addr_d  = '0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      presc_q <= '0;
      step_q  <= STEP_WIDTH'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready_o  = ready_q;
  assign cfg_err_o    = err_q;
  assign lut_addr_o   = addr_q;
  assign sample_stb_o = stb_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Bench for sine_phase_sequencer: config/run table plus scoreboarded strobe stream
// (address and spacing), with hand-written reset and STOP-resume sequences.
module tb_sine_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_presc;
  logic [5:0]  cfg_step;
  logic        cfg_err;
  logic        run;
  logic [5:0]  lut_addr;
  logic        stb;
  logic        busy;
  logic [1:0]  state;

  sine_phase_sequencer dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_presc_i (cfg_presc),
    .cfg_step_i  (cfg_step),
    .cfg_err_o   (cfg_err),
    .run_i       (run),
    .lut_addr_o  (lut_addr),
    .sample_stb_o(stb),
    .busy_o      (busy),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] presc;
    logic [5:0]  step;
    bit          exp_err;
    int          nsamp;
  } vec_t;

  vec_t vecs[6];
  int   sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_presc = 0;
  int   m_step  = 1;
  int   cyc = 0;
  int   ref_cyc = 0;
  int   prev_state = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle and score any strobe against the expected queue.
  task automatic tick();
    int exp_a;
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (state == 2'd1 && prev_state == 0) ref_cyc = cyc;
      if (stb) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_stb: got addr %0d expected no strobe", lut_addr);
        end else begin
          exp_a = sb.pop_front();
          if (int'(lut_addr) != exp_a || (cyc - ref_cyc) != m_presc + 1) begin
            errors++;
            $display("FAIL stb_addr_gap: got addr %0d gap %0d expected addr %0d gap %0d",
                     lut_addr, cyc - ref_cyc, exp_a, m_presc + 1);
          end
        end
        ref_cyc = cyc;
      end
    end
    prev_state = int'(state);
  endtask

  task automatic wait_stb(input int n);
    int c = 0;
    int g = 0;
    while (c < n && g < 2000) begin
      tick();
      g++;
      if (stb) c++;
    end
    chk("stb_timeout", c, n);
  endtask

  task automatic wait_idle();
    int g = 0;
    tick();
    while (!(state == 2'd0 && !stb) && g < 500) begin
      tick();
      g++;
    end
    chk("idle_state", int'(state), 0);
    chk("idle_busy_addr_ready", {busy, lut_addr, cfg_ready}, {1'b0, 6'd0, 1'b1});
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic push_stop(input int a_in);
    int a = a_in;
    int s;
    if (m_presc == 0) begin
      a = (a + m_step) % 48;
      sb.push_back(a);
    end
    while (a != 0) begin
      s = a + m_step;
      a = (s >= 48) ? 0 : s;
      sb.push_back(a);
    end
  endtask

  task automatic run_seq(input int n);
    int a = 0;
    for (int i = 0; i < n; i++) begin
      a = (a + m_step) % 48;
      sb.push_back(a);
    end
    tick();
    mon_en = 1'b1;
    run = 1'b1;
    wait_stb(n);
    run = 1'b0;
    push_stop(a);
    wait_idle();
  endtask

  task automatic cfg(input logic [15:0] p, input logic [5:0] s, input bit exp_err);
    tick();
    cfg_valid = 1'b1;
    cfg_presc = p;
    cfg_step  = s;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_err", int'(cfg_err), int'(exp_err));
    if (s != 0 && s < 48) begin
      m_presc = int'(p);
      m_step  = int'(s);
    end
  endtask

  initial begin
    int a;
    vecs[0] = '{presc: 16'd5, step: 6'd48, exp_err: 1'b1, nsamp: 0};
    vecs[1] = '{presc: 16'd5, step: 6'd0,  exp_err: 1'b1, nsamp: 3};
    vecs[2] = '{presc: 16'd3, step: 6'd5,  exp_err: 1'b0, nsamp: 11};
    vecs[3] = '{presc: 16'd0, step: 6'd5,  exp_err: 1'b0, nsamp: 8};
    vecs[4] = '{presc: 16'd0, step: 6'd47, exp_err: 1'b0, nsamp: 2};
    vecs[5] = '{presc: 16'd1, step: 6'd24, exp_err: 1'b0, nsamp: 2};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_presc = '0; cfg_step = '0; run = 1'b0;
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_addr", int'(lut_addr), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_err", int'(cfg_err), 0);
    rst_n = 1'b1;

    // Reset defaults: presc 0, step 1 -> strobe every cycle, 1..47,0,1.
    run_seq(49);

    foreach (vecs[i]) begin
      cfg(vecs[i].presc, vecs[i].step, vecs[i].exp_err);
      if (vecs[i].nsamp > 0) run_seq(vecs[i].nsamp);
    end

    // Config ignored while busy; STOP resumes RUN without address jump or counter clear.
    cfg(16'd3, 6'd5, 1'b0);
    sb.push_back(5); sb.push_back(10);
    tick();
    run = 1'b1;
    wait_stb(2);
    run = 1'b0;
    cfg_valid = 1'b1; cfg_presc = 16'd0; cfg_step = 6'd7;
    tick();
    chk("stop_state", int'(state), 2);
    chk("busy_ready", int'(cfg_ready), 0);
    run = 1'b1;
    sb.push_back(15); sb.push_back(20);
    wait_stb(2);
    cfg_valid = 1'b0;
    chk("busy_cfg_err", int'(cfg_err), 0);
    run = 1'b0;
    push_stop(20);
    wait_idle();

    // Reset mid-RUN.
    mon_en = 1'b0;
    cfg(16'd0, 6'd3, 1'b0);
    tick();
    run = 1'b1;
    repeat (6) tick();
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    run = 1'b0;
    tick();
    chk("mid_rst_outs", {lut_addr, state, cfg_ready, busy, stb}, {6'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    m_presc = 0;
    m_step  = 1;
    a = 0;
    run_seq(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
